// File: rtl/chacha20_ks_xor_engine.sv
// ChaCha20 keystream XOR engine: buffers 512-bit keystream blocks from an external core
// and XORs them word by word onto a byte-masked payload stream.
//   state   | meaning
//   S_IDLE  | no message active
//   S_RUN   | fetching keystream and accepting payload
//   S_DRAIN | last beat taken; flush buffer, wait for output and any outstanding request
//   S_ERR   | block counter overflowed; only a new configuration write leaves this state
module chacha20_ks_xor_engine #(
  parameter int DATA_W   = 128,
  parameter int KS_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_cfg_we,
  input  logic [31:0]         i_ctr_init,
  output logic                o_ks_req,
  input  logic                i_ks_valid,
  input  logic [511:0]        i_ks_data,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [DATA_W-1:0]   i_in_data,
  input  logic [DATA_W/8-1:0] i_in_keep,
  input  logic                i_in_last,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [DATA_W-1:0]   o_out_data,
  output logic [DATA_W/8-1:0] o_out_keep,
  output logic                o_out_last,
  output logic [31:0]         o_blk_ctr,
  output logic                o_ctr_wrap_err,
  output logic                o_busy
);
  localparam int NW    = 512 / DATA_W;
  localparam int PTR_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int CNT_W = $clog2(KS_DEPTH + 1);
  localparam int KB    = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ERR} state_t;

  state_t              r_state;
  logic [511:0]        r_fifo     [KS_DEPTH];
  logic [511:0]        w_fifo_nxt [KS_DEPTH];
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [PTR_W-1:0]    r_ptr;
  logic                r_outst, r_discard, r_ks_req;
  logic                r_out_valid, r_out_last, r_wrap_err;
  logic [DATA_W-1:0]   r_out_data;
  logic [KB-1:0]       r_out_keep;
  logic [31:0]         r_blk_ctr;
  logic [DATA_W-1:0]   w_words [NW];
  logic [DATA_W-1:0]   w_word, w_xor;
  logic                w_acc, w_pop, w_wrap, w_push, w_flush, w_req;

  for (genvar g = 0; g < NW; g++) begin : g_words
    assign w_words[g] = r_fifo[0][g*DATA_W +: DATA_W];
  end

  assign w_word     = w_words[r_ptr];
  assign o_in_ready = (r_state == S_RUN) && (r_cnt != '0) && (!r_out_valid || i_out_ready);
  assign w_acc      = i_in_valid && o_in_ready && !i_cfg_we;
  assign w_pop      = w_acc && ((r_ptr == PTR_W'(NW - 1)) || i_in_last);
  assign w_wrap     = w_pop && !i_in_last && (r_blk_ctr == 32'hFFFF_FFFF);
  // A response owed to a superseded message is never written into the buffer.
  assign w_push     = i_ks_valid && r_outst && !r_discard && !i_cfg_we && (r_state == S_RUN);
  assign w_flush    = i_cfg_we || (r_state == S_DRAIN);
  assign w_req      = (r_state == S_RUN) && !i_cfg_we && !r_outst &&
                      (r_cnt < CNT_W'(KS_DEPTH)) && !w_wrap && !(w_acc && i_in_last);

  always_comb begin
    w_xor = '0;
    for (int b = 0; b < KB; b++)
      w_xor[b*8 +: 8] = i_in_keep[b] ? (i_in_data[b*8 +: 8] ^ w_word[b*8 +: 8]) : 8'h00;
  end

  always_comb begin
    w_fifo_nxt = r_fifo;
    w_cnt_nxt  = r_cnt;
    if (w_flush) begin
      w_cnt_nxt = '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < KS_DEPTH - 1; i++) w_fifo_nxt[i] = r_fifo[i+1];
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      if (w_push) begin
        for (int i = 0; i < KS_DEPTH; i++)
          if (w_cnt_nxt == CNT_W'(i)) w_fifo_nxt[i] = i_ks_data;
        w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < KS_DEPTH; i++) r_fifo[i] <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_outst     <= 1'b0;
      r_discard   <= 1'b0;
      r_ks_req    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_blk_ctr   <= '0;
      r_wrap_err  <= 1'b0;
    end else begin
      r_fifo   <= w_fifo_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ks_req <= w_req;
      if (i_cfg_we) begin
        r_state     <= S_RUN;
        r_ptr       <= '0;
        r_blk_ctr   <= i_ctr_init;
        r_wrap_err  <= 1'b0;
        r_out_valid <= 1'b0;
        // Still owed a block: keep waiting for it, but throw it away when it lands.
        r_outst     <= r_outst && !i_ks_valid;
        r_discard   <= r_outst && !i_ks_valid;
      end else begin
        if (w_req) begin
          r_outst <= 1'b1;
        end else if (i_ks_valid && r_outst) begin
          r_outst   <= 1'b0;
          r_discard <= 1'b0;
        end
        if (w_acc) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_xor;
          r_out_keep  <= i_in_keep;
          r_out_last  <= i_in_last;
          r_ptr       <= w_pop ? '0 : r_ptr + PTR_W'(1);
          if (w_pop) r_blk_ctr <= r_blk_ctr + 32'd1;
        end else if (i_out_ready) begin
          r_out_valid <= 1'b0;
        end
        case (r_state)
          S_RUN: begin
            if (w_wrap) begin
              r_state    <= S_ERR;
              r_wrap_err <= 1'b1;
            end else if (w_acc && i_in_last) begin
              r_state <= S_DRAIN;
            end
          end
          S_DRAIN: if (!r_out_valid && !r_outst) r_state <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  assign o_ks_req       = r_ks_req;
  assign o_out_valid    = r_out_valid;
  assign o_out_data     = r_out_data;
  assign o_out_keep     = r_out_keep;
  assign o_out_last     = r_out_last;
  assign o_blk_ctr      = r_blk_ctr;
  assign o_ctr_wrap_err = r_wrap_err;
  assign o_busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_chacha20_ks_xor_engine.sv
// Directed bench for chacha20_ks_xor_engine: a keystream responder and an output
// scoreboard run inside a per-cycle tick task driven from one initial block.
module tb_chacha20_ks_xor_engine;
  localparam int DW = 128;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_cfg_we, i_ks_valid, i_in_valid, i_in_last, i_out_ready;
  logic [31:0]   i_ctr_init;
  logic [511:0]  i_ks_data;
  logic [DW-1:0] i_in_data;
  logic [KW-1:0] i_in_keep;
  logic          o_ks_req, o_in_ready, o_out_valid, o_out_last, o_ctr_wrap_err, o_busy;
  logic [DW-1:0] o_out_data;
  logic [KW-1:0] o_out_keep;
  logic [31:0]   o_blk_ctr;

  always #5 clk = ~clk;

  chacha20_ks_xor_engine #(.DATA_W(DW), .KS_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_we(i_cfg_we), .i_ctr_init(i_ctr_init),
    .o_ks_req(o_ks_req), .i_ks_valid(i_ks_valid), .i_ks_data(i_ks_data),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .i_in_keep(i_in_keep), .i_in_last(i_in_last), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_keep(o_out_keep),
    .o_out_last(o_out_last), .o_blk_ctr(o_blk_ctr), .o_ctr_wrap_err(o_ctr_wrap_err),
    .o_busy(o_busy)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } out_t;

  out_t exp_q[$];
  out_t cur_exp;
  int   n_cmp = 0, n_err = 0, n_req = 0, n_out = 0;
  int   ks_seed = 0, ks_delay = 2, ks_cd = 0;
  bit   ks_pend = 0, acc = 0;

  function automatic logic [511:0] blk(int s);
    logic [511:0] b;
    for (int j = 0; j < 64; j++) b[j*8 +: 8] = 8'(j) ^ 8'(s * 65);
    return b;
  endfunction

  function automatic logic [DW-1:0] word(int s, int i);
    logic [511:0] b;
    b = blk(s);
    return b[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] xmask(logic [DW-1:0] d, logic [KW-1:0] k, logic [DW-1:0] w);
    logic [DW-1:0] r;
    for (int j = 0; j < KW; j++) r[j*8 +: 8] = k[j] ? (d[j*8 +: 8] ^ w[j*8 +: 8]) : 8'h00;
    return r;
  endfunction

  function automatic logic [181:0] rstvec();
    return {o_ks_req, o_in_ready, o_out_valid, o_out_data, o_out_keep, o_out_last,
            o_blk_ctr, o_ctr_wrap_err, o_busy};
  endfunction

  task automatic check(string tag, logic [639:0] obs, logic [639:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge (responder, acceptance, scoreboard), drive after posedge.
  task automatic tick();
    @(negedge clk);
    acc = 0;
    if (o_ks_req) begin
      n_req++;
      if (!ks_pend) begin
        ks_pend = 1;
        ks_cd   = ks_delay;
      end
    end
    if (i_in_valid && o_in_ready) begin
      acc = 1;
      exp_q.push_back(cur_exp);
    end
    if (o_out_valid && i_out_ready) begin
      n_out++;
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_out observed=%0h expected=none", o_out_data);
      end
      if (exp_q.size() > 0) begin
        out_t e;
        e = exp_q.pop_front();
        check("out_data", o_out_data, e.d);
        check("out_keep", o_out_keep, e.k);
        check("out_last", o_out_last, e.l);
      end
    end
    @(posedge clk);
    #1;
    i_ks_valid = 1'b0;
    if (ks_pend) begin
      if (ks_cd == 0) begin
        i_ks_valid = 1'b1;
        i_ks_data  = blk(ks_seed);
        ks_seed++;
        ks_pend = 0;
      end else begin
        ks_cd--;
      end
    end
  endtask

  task automatic send_beat(logic [DW-1:0] d, logic [KW-1:0] k, logic l, logic [DW-1:0] w,
                           int bound, output bit ok);
    cur_exp    = '{d: xmask(d, k, w), k: k, l: l};
    i_in_data  = d;
    i_in_keep  = k;
    i_in_last  = l;
    i_in_valid = 1'b1;
    ok = 0;
    for (int t = 0; t < bound && !ok; t++) begin
      tick();
      ok = acc;
    end
    i_in_valid = 1'b0;
  endtask

  task automatic beat(logic [DW-1:0] d, logic [KW-1:0] k, logic l, logic [DW-1:0] w);
    bit ok;
    send_beat(d, k, l, w, 100, ok);
    check("accept_tmo", ok, 1);
  endtask

  task automatic cfg(logic [31:0] ctr);
    i_cfg_we   = 1'b1;
    i_ctr_init = ctr;
    tick();
    i_cfg_we   = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    for (int t = 0; t < 200 && o_busy; t++) tick();
    check(tag, o_busy, 0);
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int  base, r0, r1;
    bit  ok;
    logic [DW-1:0] d1, d2, d3;
    rst_n = 1'b0; i_cfg_we = 0; i_ctr_init = '0; i_ks_valid = 0; i_ks_data = '0;
    i_in_valid = 0; i_in_data = '0; i_in_keep = '0; i_in_last = 0; i_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", rstvec(), '0);
    rst_n = 1'b1;
    tick();

    // Four full beats of zero payload return the raw block words.
    base = ks_seed;
    cfg(32'd1);
    check("blk_ctr_load", o_blk_ctr, 32'd1);
    for (int i = 0; i < 4; i++) begin
      beat('0, '1, i == 3, word(base, i));
      if (i == 2) check("blk_ctr_mid", o_blk_ctr, 32'd1);
    end
    check("blk_ctr_inc", o_blk_ctr, 32'd2);
    wait_idle("idle_after_msg1");

    // Partial keep zeroes masked bytes; the next beat still moves to word 1.
    base = ks_seed;
    cfg(32'd5);
    beat({DW{1'b1}}, 16'h00FF, 1'b0, word(base, 0));
    d1 = rnd();
    beat(d1, '1, 1'b1, word(base, 1));
    check("blk_ctr_partial", o_blk_ctr, 32'd6);
    wait_idle("idle_after_msg2");

    // Backpressure: buffer fills to two blocks, then input stalls until out_ready returns.
    i_out_ready = 1'b0;
    r0 = n_req;
    base = ks_seed;
    cfg(32'd2);
    beat('0, '1, 1'b0, word(base, 0));
    d1 = rnd(); d2 = rnd(); d3 = rnd();
    send_beat(d1, '1, 1'b0, word(base, 1), 20, ok);
    check("stall_no_accept", ok, 0);
    check("stall_two_reqs", n_req - r0, 2);
    check("stall_in_ready", o_in_ready, 0);
    check("stall_out_valid", o_out_valid, 1);
    i_out_ready = 1'b1;
    beat(d1, '1, 1'b0, word(base, 1));
    beat(d2, '1, 1'b0, word(base, 2));
    beat(d3, 16'hF0F0, 1'b1, word(base, 3));
    wait_idle("idle_after_msg3");

    // Counter overflow without in_last: four outputs, then ERR with input and requests frozen.
    base = ks_seed;
    cfg(32'hFFFF_FFFF);
    r0 = n_out;
    for (int i = 0; i < 4; i++) beat(rnd(), '1, 1'b0, word(base, i));
    r1 = n_req;
    send_beat(rnd(), '1, 1'b0, word(base + 1, 0), 10, ok);
    check("err_no_accept", ok, 0);
    check("err_out_count", n_out - r0, 4);
    check("err_flag", o_ctr_wrap_err, 1);
    check("err_in_ready", o_in_ready, 0);
    check("err_busy", o_busy, 1);
    check("err_no_req", n_req - r1, 0);

    // Reconfiguring with a request outstanding: its response is dropped, the next block is used.
    ks_delay = 6;
    cfg(32'd10);
    check("wrap_clr", o_ctr_wrap_err, 0);
    r0 = n_req;
    for (int t = 0; t < 20 && n_req == r0; t++) tick();
    check("req_seen", n_req - r0, 1);
    tick();
    cfg(32'd20);
    r0 = n_req;
    for (int t = 0; t < 30 && ks_pend; t++) tick();
    check("stale_returned", ks_pend, 0);
    check("no_req_before_return", n_req - r0, 0);
    base = ks_seed;
    beat('0, '1, 1'b1, word(base, 0));
    check("blk_ctr_reload", o_blk_ctr, 32'd21);
    wait_idle("idle_after_msg5");
    ks_delay = 2;

    // Asynchronous reset mid-message with an output pending.
    i_out_ready = 1'b0;
    base = ks_seed;
    cfg(32'd7);
    beat({DW{1'b1}}, '1, 1'b0, word(base, 0));
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", rstvec(), '0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    i_out_ready = 1'b1;
    repeat (8) tick();
    check("post_rst_in_ready", o_in_ready, 0);
    check("post_rst_out_valid", o_out_valid, 0);
    check("post_rst_busy", o_busy, 0);
    base = ks_seed;
    cfg(32'd3);
    d1 = rnd();
    beat(d1, '1, 1'b0, word(base, 0));
    beat('0, 16'h8001, 1'b1, word(base, 1));
    check("blk_ctr_after_rst", o_blk_ctr, 32'd4);
    wait_idle("idle_after_msg6");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
